fc_layer_param: RTL and testbench

//  Parametrised fully-connected layer engine for LeNet/VGG16 accelerator: y[r] = sat(bias[r] + sum_c W[r][c]*x[c]) for r in 0..OUT_SIZE-1.

---
 rtl/fc_layer_param_pkg.sv | 25 ++
 rtl/fc_layer_param_mac_lanes.sv | 19 +
 rtl/fc_layer_param.sv | 130 +++++++++++++
 tb/tb_fc_layer_param.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fc_layer_param_pkg.sv
// fc_layer_param_pkg: one-hot FSM encoding, clog2 and shift/saturate helper for fc_layer_param.
package fc_layer_param_pkg;
  typedef enum logic [6:0] {
    S_IDLE  = 7'h01,
    S_BIAS  = 7'h02,
    S_LW    = 7'h04,
    S_LX    = 7'h08,
    S_MAC   = 7'h10,
    S_STORE = 7'h20,
    S_DONE  = 7'h40
  } state_t;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
  // Arithmetic shift then clamp into a dw-bit signed range; caller truncates to dw bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] a, input int frac, input int dw);
    logic signed [63:0] s, hi, lo;
    s = a >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (s > hi) ? hi : (s < lo) ? lo : s;
  endfunction
endpackage

// File: rtl/fc_layer_param_mac_lanes.sv
// fc_mac_lanes: combinational LANES-wide signed multiply and sum into an ACC_W result.
module fc_mac_lanes #(
  parameter int DATA_W = 8,
  parameter int LANES  = 25,
  parameter int ACC_W  = 27
) (
  input  logic [LANES*DATA_W-1:0] i_w,
  input  logic [LANES*DATA_W-1:0] i_x,
  output logic signed [ACC_W-1:0] o_sum
);
  logic signed [2*DATA_W-1:0] w_p [LANES];
  for (genvar j = 0; j < LANES; j++) begin : g_mul
    assign w_p[j] = $signed(i_w[j*DATA_W +: DATA_W]) * $signed(i_x[j*DATA_W +: DATA_W]);
  end
  always_comb begin
    o_sum = '0;
    for (int i = 0; i < LANES; i++) o_sum = o_sum + {{(ACC_W-2*DATA_W){w_p[i][2*DATA_W-1]}}, w_p[i]};
  end
endmodule

// File: rtl/fc_layer_param.sv
// fc_layer_param: fully-connected layer engine y[r] = sat(bias[r] + sum W[r][c]*x[c]).
// Define FC_RELU_EN to clamp negative outputs to zero (fused ReLU).
module fc_layer_param
  import fc_layer_param_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IN_SIZE   = 800,
  parameter int OUT_SIZE  = 500,
  parameter int LANES     = 25,
  parameter int FRAC_BITS = 0,
  parameter int RD_LAT    = 2,
  parameter int W_BASE    = 25500,
  parameter int B_BASE    = 430570,
  parameter int X_BASE    = 17600,
  parameter int Y_BASE    = 18400,
  parameter int WADDR_W   = 19,
  parameter int RADDR_W   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               bias_weights_bram_ena,
  output logic [WADDR_W-1:0] bias_weights_bram_addra,
  input  logic [DATA_W-1:0]  bias_weights_bram_douta,
  output logic               result_bram_ena,
  output logic               result_bram_wea,
  output logic [RADDR_W-1:0] result_bram_addra,
  output logic [DATA_W-1:0]  result_bram_dina,
  input  logic [DATA_W-1:0]  result_bram_douta
);
  localparam int ACC_W = 2*DATA_W + clog2(IN_SIZE) + 1;
  localparam int LW = clog2(LANES + RD_LAT + 1);
  localparam int CW = clog2(IN_SIZE + 1);
  localparam int RW = clog2(OUT_SIZE + 1);
  localparam logic [LW-1:0] C_LANES = LW'(LANES);
  localparam logic [LW-1:0] C_BEND = LW'(RD_LAT);
  localparam logic [LW-1:0] C_VEND = LW'(LANES + RD_LAT - 1);
  localparam logic [CW-1:0] C_IN = CW'(IN_SIZE);
  localparam logic [RW-1:0] C_LAST = RW'(OUT_SIZE - 1);
  localparam logic [WADDR_W-1:0] LW_BASE = WADDR_W'(W_BASE);
  localparam logic [WADDR_W-1:0] LB_BASE = WADDR_W'(B_BASE);
  localparam logic [RADDR_W-1:0] LX_BASE = RADDR_W'(X_BASE);
  localparam logic [RADDR_W-1:0] LY_BASE = RADDR_W'(Y_BASE);

  state_t r_state, w_nxt;
  logic [LW-1:0] r_cnt, w_lane;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [WADDR_W-1:0] r_wptr;
  logic [LANES*DATA_W-1:0] r_w, r_x;
  logic signed [ACC_W-1:0] r_acc, w_sum, w_bias;
  logic [DATA_W-1:0] w_sat, w_y;
  logic w_issue, w_cap, w_end, w_bias_rd, w_w_rd, w_x_rd, w_store;

  fc_mac_lanes #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W)) u_mac (
    .i_w(r_w), .i_x(r_x), .o_sum(w_sum)
  );

  // r_cnt walks each load phase: reads issue on 0..LANES-1, data lands RD_LAT later.
  assign w_issue = r_cnt < C_LANES;
  assign w_cap = r_cnt >= C_BEND;
  assign w_lane = r_cnt - C_BEND;
  assign w_end = r_cnt == C_VEND;
  assign w_bias_rd = r_state == S_BIAS && r_cnt == '0;
  assign w_w_rd = r_state == S_LW && w_issue;
  assign w_x_rd = r_state == S_LX && w_issue;
  assign w_store = r_state == S_STORE;
  assign w_bias = {{(ACC_W-DATA_W){bias_weights_bram_douta[DATA_W-1]}}, bias_weights_bram_douta} <<< FRAC_BITS;
  assign w_sat = DATA_W'(sat_shift({{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc}, FRAC_BITS, DATA_W));
`ifdef FC_RELU_EN
  assign w_y = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign w_y = w_sat;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = start ? S_BIAS : S_IDLE;
      S_BIAS:  w_nxt = (r_cnt == C_BEND) ? S_LW : S_BIAS;
      S_LW:    w_nxt = w_end ? S_LX : S_LW;
      S_LX:    w_nxt = w_end ? S_MAC : S_LX;
      S_MAC:   w_nxt = (r_col == C_IN) ? S_STORE : S_LW;
      S_STORE: w_nxt = (r_row == C_LAST) ? S_DONE : S_BIAS;
      default: w_nxt = S_IDLE;
    endcase
    busy = !(r_state inside {S_IDLE, S_DONE});
    done = r_state == S_DONE;
    bias_weights_bram_ena = w_bias_rd | w_w_rd;
    bias_weights_bram_addra = w_bias_rd ? LB_BASE + WADDR_W'(r_row) : w_w_rd ? r_wptr + WADDR_W'(r_cnt) : '0;
    result_bram_ena = w_x_rd | w_store;
    result_bram_wea = w_store;
    result_bram_addra = w_x_rd ? LX_BASE + RADDR_W'(r_col) + RADDR_W'(r_cnt) :
                        w_store ? LY_BASE + RADDR_W'(r_row) : '0;
    result_bram_dina = w_store ? w_y : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_col <= '0;
      r_row <= '0;
      r_wptr <= '0;
      r_w <= '0;
      r_x <= '0;
      r_acc <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= (w_nxt != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      if (r_state == S_IDLE && start) begin
        r_row <= '0;
        r_col <= '0;
        r_wptr <= LW_BASE;
      end
      if (r_state == S_BIAS && r_cnt == C_BEND) r_acc <= w_bias;
      if (r_state == S_LW && w_cap) r_w[w_lane*DATA_W +: DATA_W] <= bias_weights_bram_douta;
      if (r_state == S_LW && w_end) r_wptr <= r_wptr + WADDR_W'(LANES);
      if (r_state == S_LX && w_cap) r_x[w_lane*DATA_W +: DATA_W] <= result_bram_douta;
      if (r_state == S_LX && w_end) r_col <= r_col + CW'(LANES);
      if (r_state == S_MAC) r_acc <= r_acc + w_sum;
      if (w_store) begin
        r_row <= r_row + 1'b1;
        r_col <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fc_layer_param.sv
// tb_fc_layer_param: four small fc_layer_param builds (RD_LAT 2/1/3, FRAC_BITS 2) against an arithmetic reference.
module tb_fc_layer_param;
  localparam int IN = 4, OUT = 2, LN = 2, WB = 16, BB = 4, XB = 8, YB = 20;
`ifdef FC_RELU_EN
  localparam int NEG1 = 0, NEGSAT = 0;
`else
  localparam int NEG1 = -1, NEGSAT = -128;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] start = '0, busy, done, wena, rena, wea;
  logic [5:0] waddr [4], raddr [4];
  logic [7:0] wdout [4], rdout [4], din [4];
  logic signed [7:0] wmem [4][64], rmem [4][64];
  int wr_cnt [4] = '{default: 0};
  int done_cnt [4] = '{default: 0};
  int bad_wr [4] = '{default: 0};
  int ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int RL = (g == 1) ? 1 : (g == 2) ? 3 : 2;
    localparam int FB = (g == 3) ? 2 : 0;
    logic [7:0] wp [RL], rp [RL];
    always @(posedge clk) begin
      if (wena[g]) wp[0] <= wmem[g][waddr[g]];
      if (rena[g]) rp[0] <= rmem[g][raddr[g]];
      for (int i = 1; i < RL; i++) begin
        wp[i] <= wp[i-1];
        rp[i] <= rp[i-1];
      end
      if (rena[g] && wea[g]) begin
        rmem[g][raddr[g]] <= din[g];
        wr_cnt[g] <= wr_cnt[g] + 1;
      end
      if (wea[g] && (!rena[g] || raddr[g] < 6'(YB) || raddr[g] >= 6'(YB + OUT))) bad_wr[g] <= bad_wr[g] + 1;
      if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
    end
    assign wdout[g] = wp[RL-1];
    assign rdout[g] = rp[RL-1];
    fc_layer_param #(
      .DATA_W(8), .IN_SIZE(IN), .OUT_SIZE(OUT), .LANES(LN), .FRAC_BITS(FB), .RD_LAT(RL),
      .W_BASE(WB), .B_BASE(BB), .X_BASE(XB), .Y_BASE(YB), .WADDR_W(6), .RADDR_W(6)
    ) dut (
      .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .bias_weights_bram_ena(wena[g]), .bias_weights_bram_addra(waddr[g]),
      .bias_weights_bram_douta(wdout[g]),
      .result_bram_ena(rena[g]), .result_bram_wea(wea[g]), .result_bram_addra(raddr[g]),
      .result_bram_dina(din[g]), .result_bram_douta(rdout[g])
    );
  end

  function automatic int rl(input int g);
    return (g == 1) ? 1 : (g == 2) ? 3 : 2;
  endfunction

  // Reference: y = clamp((bias*2^f + dot(W_row, x)) / 2^f floored), optional ReLU.
  function automatic int ref_y(input int g, input int r);
    int f, acc, y;
    f = (g == 3) ? 2 : 0;
    acc = int'(wmem[g][BB+r]) * (1 << f);
    for (int c = 0; c < IN; c++) acc += int'(wmem[g][WB+r*IN+c]) * int'(rmem[g][XB+c]);
    y = acc >>> f;
    y = (y > 127) ? 127 : (y < -128) ? -128 : y;
`ifdef FC_RELU_EN
    if (y < 0) y = 0;
`endif
    return y;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int g, input int b[2], input int w[8], input int x[4]);
    for (int r = 0; r < OUT; r++) wmem[g][BB+r] = 8'(b[r]);
    for (int i = 0; i < OUT*IN; i++) wmem[g][WB+i] = 8'(w[i]);
    for (int c = 0; c < IN; c++) rmem[g][XB+c] = 8'(x[c]);
  endtask

  task automatic rand_load(input int g);
    for (int r = 0; r < OUT; r++) wmem[g][BB+r] = 8'($urandom_range(0, 255));
    for (int i = 0; i < OUT*IN; i++) wmem[g][WB+i] = 8'($urandom_range(0, 255));
    for (int c = 0; c < IN; c++) rmem[g][XB+c] = 8'($urandom_range(0, 255));
  endtask

  // Runs one layer on instance g; rst_at >= 1 asserts reset in that cycle and abandons the layer.
  task automatic run(input int g, input int rst_at, input bit repulse);
    int cyc, w0, d0, lat;
    lat = OUT * (1 + rl(g) + (IN/LN) * (2*(LN + rl(g)) + 1) + 1) + 1;
    for (int r = 0; r < OUT; r++) rmem[g][YB+r] = 8'sd85;
    w0 = wr_cnt[g];
    d0 = done_cnt[g];
    @(negedge clk) start[g] = 1'b1;
    @(negedge clk) start[g] = 1'b0;
    cyc = 1;
    chk("busy_after_start", int'(busy[g]), 1);
    while (!done[g] && cyc < 1000) begin
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_ctrl_outputs", int'({busy[g], done[g], wena[g], rena[g], wea[g]}), 0);
        chk("rst_addr_data", int'(waddr[g]) + int'(raddr[g]) + int'(din[g]), 0);
        @(negedge clk) rst = 1'b0;
        chk("rst_no_write_row1", int'(rmem[g][YB+1]), 85);
        chk("rst_row0_kept", int'(rmem[g][YB]), ref_y(g, 0));
        chk("rst_write_count", wr_cnt[g] - w0, 1);
        return;
      end
      start[g] = repulse && cyc == 5;
      @(negedge clk);
      cyc++;
    end
    start[g] = 1'b0;
    chk("latency", cyc, lat);
    chk("busy_at_done", int'(busy[g]), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done[g]), 0);
    chk("write_count", wr_cnt[g] - w0, OUT);
    chk("done_count", done_cnt[g] - d0, 1);
    for (int r = 0; r < OUT; r++) chk("y_vs_model", int'(rmem[g][YB+r]), ref_y(g, r));
  endtask

  initial begin
    int w0, d0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", int'({busy, done, wena, rena, wea}), 0);
    chk("reset_addr", int'(waddr[0]) + int'(raddr[1]) + int'(din[2]) + int'(waddr[3]), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      load(g, '{5, 0}, '{1, 1, 1, 1, -1, 0, 0, 0}, '{1, 2, 3, 4});
      run(g, 0, 1'b0);
      chk("t1_y0", int'(rmem[g][YB]), 15);
      chk("t1_y1", int'(rmem[g][YB+1]), NEG1);
    end
    load(0, '{127, 0}, '{127, 127, 127, 127, -128, -128, -128, -128}, '{127, 127, 127, 127});
    run(0, 0, 1'b0);
    chk("t2_pos_sat", int'(rmem[0][YB]), 127);
    chk("t2_neg_sat", int'(rmem[0][YB+1]), NEGSAT);
    load(3, '{1, -3}, '{3, 1, 0, 0, 0, 0, 0, 0}, '{4, 4, 0, 0});
    run(3, 0, 1'b0);
    chk("t3_frac_y0", int'(rmem[3][YB]), 5);
    load(0, '{5, 0}, '{1, 1, 1, 1, -1, 0, 0, 0}, '{1, 2, 3, 4});
    run(0, 1 + 22 + (1 + 2) + (LN + 2) + 1, 1'b0);
    run(0, 0, 1'b0);
    chk("t4_y0", int'(rmem[0][YB]), 15);
    chk("t4_y1", int'(rmem[0][YB+1]), NEG1);
    run(0, 0, 1'b1);
    w0 = wr_cnt[0];
    d0 = done_cnt[0];
    repeat (40) @(negedge clk);
    chk("t5_no_extra_writes", wr_cnt[0] - w0, 0);
    chk("t5_no_extra_done", done_cnt[0] - d0, 0);
    for (int i = 0; i < 12; i++) begin
      rand_load(i % 4);
      run(i % 4, 0, 1'b0);
    end
    chk("no_stray_writes", bad_wr[0] + bad_wr[1] + bad_wr[2] + bad_wr[3], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
